// File: rtl/chip8_pkg.sv
// Shared types for the CHIP-8 memory arbiter: access type, access size and
// arbiter FSM state encodings.
package chip8_pkg;

    // Downstream access type carried with every request.
    typedef enum logic [1:0] {
        ACC_FETCH = 2'd0,
        ACC_LOAD  = 2'd1,
        ACC_STORE = 2'd2,
        ACC_VIDEO = 2'd3
    } acc_type_e;

    // Access size: byte or 16-bit word.
    typedef enum logic {
        SIZE_BYTE = 1'b0,
        SIZE_WORD = 1'b1
    } size_e;

    // Arbiter transaction FSM.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/chip8_rr_arbiter.sv
// Combinational round-robin grant: searches the request vector starting one
// past last_grant (wrapping at NUM_CH) and returns a one-hot grant.
//   req        : per-channel request vector
//   last_grant : index of the most recently granted channel
//   grant      : one-hot grant, all zero when nothing requests
module chip8_rr_arbiter #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned LG_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [LG_W-1:0]   last_grant,
    output logic [NUM_CH-1:0] grant
);

    // First requester at or after last_grant+1, modulo NUM_CH.
    always_comb begin
        int unsigned cand;
        logic        found;
        grant = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = (32'(last_grant) + i) % NUM_CH;
            if (!found && req[LG_W'(cand)]) begin
                grant[LG_W'(cand)] = 1'b1;
                found              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// CHIP-8 memory arbiter: round-robin selection among NUM_CH requesters
// (processor, video, debug) onto a single downstream memory port, one
// transaction outstanding at a time.
// Optional feature macro: CHIP8_ARB_TIMEOUT_EN adds an ISSUE/WAIT watchdog
// that completes the transaction with an error after TIMEOUT_CYCLES.
//   clk_in, rst_in            : clock, async active-low reset
//   req_*_in / req_ready_out  : per-channel request and one-hot accept
//   resp_*_out                : one-hot response pulse, error, shared data
//   mem_*_out / mem_*_in      : downstream request and response
module chip8_mem_arbiter
    import chip8_pkg::*;
#(
    parameter int unsigned NUM_CH         = 3,
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic [NUM_CH-1:0]              req_valid_in,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  req_addr_in,
    input  logic [NUM_CH-1:0][DATA_W-1:0]  req_data_in,
    input  logic [NUM_CH-1:0]              req_we_in,
    input  logic [NUM_CH-1:0]              req_size_in,
    input  logic [NUM_CH-1:0][1:0]         req_type_in,
    output logic [NUM_CH-1:0]              req_ready_out,
    output logic [NUM_CH-1:0]              resp_valid_out,
    output logic [NUM_CH-1:0]              resp_err_out,
    output logic [DATA_W-1:0]              resp_data_out,
    output logic [ADDR_W-1:0]              mem_addr_out,
    output logic [DATA_W-1:0]              mem_data_out,
    output logic                           mem_we_out,
    output logic                           mem_size_out,
    output logic [1:0]                     mem_type_out,
    output logic                           mem_valid_out,
    input  logic                           mem_ready_in,
    input  logic                           mem_valid_in,
    input  logic [DATA_W-1:0]              mem_data_in
);

    localparam int unsigned LG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    arb_state_e        state;
    logic [LG_W-1:0]   last_grant;
    logic [NUM_CH-1:0] gnt_q;
    acc_type_e         type_q;
    size_e             size_q;
    logic [NUM_CH-1:0] grant_c;
    logic [LG_W-1:0]   grant_idx_c;
    logic              timeout_c;

    chip8_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .LG_W   (LG_W)
    ) u_rr (
        .req        (req_valid_in),
        .last_grant (last_grant),
        .grant      (grant_c)
    );

    // One-hot grant to index.
    always_comb begin
        grant_idx_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant_c[LG_W'(i)]) grant_idx_c = LG_W'(i);
        end
    end

    // Accept is combinational in IDLE; gated by reset so outputs read 0 while held.
    assign req_ready_out = (state == ST_IDLE && rst_in) ? grant_c : '0;
    assign mem_type_out  = type_q;
    assign mem_size_out  = size_q;

    // Transaction FSM with registered downstream/response outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state          <= ST_IDLE;
            last_grant     <= LG_W'(NUM_CH - 1);
            gnt_q          <= '0;
            mem_addr_out   <= '0;
            mem_data_out   <= '0;
            mem_we_out     <= 1'b0;
            size_q         <= SIZE_BYTE;
            type_q         <= ACC_FETCH;
            mem_valid_out  <= 1'b0;
            resp_valid_out <= '0;
            resp_data_out  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|grant_c) begin
                        gnt_q         <= grant_c;
                        last_grant    <= grant_idx_c;
                        mem_addr_out  <= req_addr_in[grant_idx_c];
                        mem_data_out  <= req_data_in[grant_idx_c];
                        mem_we_out    <= req_we_in[grant_idx_c];
                        size_q        <= size_e'(req_size_in[grant_idx_c]);
                        type_q        <= acc_type_e'(req_type_in[grant_idx_c]);
                        mem_valid_out <= 1'b1;
                        state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_ready_in) begin
                        mem_valid_out <= 1'b0;
                        state         <= ST_WAIT;
                    end else if (timeout_c) begin
                        mem_valid_out  <= 1'b0;
                        resp_valid_out <= gnt_q;
                        resp_data_out  <= '0;
                        state          <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (mem_valid_in) begin
                        resp_valid_out <= gnt_q;
                        resp_data_out  <= mem_we_out ? '0 : mem_data_in;
                        state          <= ST_RESP;
                    end else if (timeout_c) begin
                        resp_valid_out <= gnt_q;
                        resp_data_out  <= '0;
                        state          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    resp_valid_out <= '0;
                    resp_data_out  <= '0;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CHIP8_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Fires on the last allowed ISSUE/WAIT cycle unless the normal event wins.
    assign timeout_c = ((state == ST_ISSUE && !mem_ready_in) ||
                        (state == ST_WAIT  && !mem_valid_in)) &&
                       (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counter and error flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tmo_cnt      <= '0;
            resp_err_out <= '0;
        end else begin
            if (state == ST_ISSUE || state == ST_WAIT) tmo_cnt <= tmo_cnt + CNT_W'(1);
            else                                       tmo_cnt <= '0;
            resp_err_out <= timeout_c ? gnt_q : '0;
        end
    end
`else
    logic unused_timeout;

    assign timeout_c      = 1'b0;
    assign resp_err_out   = '0;
    assign unused_timeout = |32'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed self-checking bench for chip8_mem_arbiter.
module tb_chip8_mem_arbiter;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned TMO    = 16;

    logic                          clk_in = 1'b0;
    logic                          rst_in;
    logic [NUM_CH-1:0]             req_valid_in;
    logic [NUM_CH-1:0][ADDR_W-1:0] req_addr_in;
    logic [NUM_CH-1:0][DATA_W-1:0] req_data_in;
    logic [NUM_CH-1:0]             req_we_in;
    logic [NUM_CH-1:0]             req_size_in;
    logic [NUM_CH-1:0][1:0]        req_type_in;
    logic [NUM_CH-1:0]             req_ready_out;
    logic [NUM_CH-1:0]             resp_valid_out;
    logic [NUM_CH-1:0]             resp_err_out;
    logic [DATA_W-1:0]             resp_data_out;
    logic [ADDR_W-1:0]             mem_addr_out;
    logic [DATA_W-1:0]             mem_data_out;
    logic                          mem_we_out;
    logic                          mem_size_out;
    logic [1:0]                    mem_type_out;
    logic                          mem_valid_out;
    logic                          mem_ready_in;
    logic                          mem_valid_in;
    logic [DATA_W-1:0]             mem_data_in;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    chip8_mem_arbiter #(
        .NUM_CH         (NUM_CH),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .req_valid_in   (req_valid_in),
        .req_addr_in    (req_addr_in),
        .req_data_in    (req_data_in),
        .req_we_in      (req_we_in),
        .req_size_in    (req_size_in),
        .req_type_in    (req_type_in),
        .req_ready_out  (req_ready_out),
        .resp_valid_out (resp_valid_out),
        .resp_err_out   (resp_err_out),
        .resp_data_out  (resp_data_out),
        .mem_addr_out   (mem_addr_out),
        .mem_data_out   (mem_data_out),
        .mem_we_out     (mem_we_out),
        .mem_size_out   (mem_size_out),
        .mem_type_out   (mem_type_out),
        .mem_valid_out  (mem_valid_out),
        .mem_ready_in   (mem_ready_in),
        .mem_valid_in   (mem_valid_in),
        .mem_data_in    (mem_data_in)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NUM_CH-1:0] exp_gnt;
        int unsigned       ch;

        rst_in       = 1'b0;
        req_valid_in = '0;
        req_addr_in  = '0;
        req_data_in  = '0;
        req_we_in    = '0;
        req_size_in  = '0;
        req_type_in  = '0;
        mem_ready_in = 1'b0;
        mem_valid_in = 1'b0;
        mem_data_in  = '0;
        #1;
        check("rst_ready",      32'(req_ready_out),  0);
        check("rst_mem_valid",  32'(mem_valid_out),  0);
        check("rst_mem_addr",   32'(mem_addr_out),   0);
        check("rst_resp_valid", 32'(resp_valid_out), 0);
        check("rst_resp_data",  32'(resp_data_out),  0);
        repeat (2) @(posedge clk_in);
        #2;
        rst_in = 1'b1;

        // Single read by ch0.
        tick();
        req_valid_in   = 3'b001;
        req_addr_in[0] = 12'h200;
        req_size_in[0] = 1'b1;
        mem_ready_in   = 1'b1;
        #1;
        check("rd_ready", 32'(req_ready_out), 32'b001);
        tick();
        req_valid_in = '0;
        #1;
        check("rd_mem_valid", 32'(mem_valid_out), 1);
        check("rd_mem_addr",  32'(mem_addr_out),  32'h200);
        check("rd_mem_we",    32'(mem_we_out),    0);
        check("rd_ready_off", 32'(req_ready_out), 0);
        tick();
        mem_valid_in = 1'b1;
        mem_data_in  = 16'h00E0;
        #1;
        check("rd_wait_mem_valid", 32'(mem_valid_out),  0);
        check("rd_wait_resp",      32'(resp_valid_out), 0);
        tick();
        mem_valid_in = 1'b0;
        #1;
        check("rd_resp_valid", 32'(resp_valid_out), 32'b001);
        check("rd_resp_data",  32'(resp_data_out),  32'h00E0);
        check("rd_resp_err",   32'(resp_err_out),   0);
        tick();
        #1;
        check("rd_resp_pulse", 32'(resp_valid_out), 0);

        // Round-robin from a fresh reset, all channels requesting.
        rst_in = 1'b0;
        #1;
        check("rr_rst_addr", 32'(mem_addr_out), 0);
        rst_in         = 1'b1;
        req_valid_in   = 3'b111;
        req_addr_in[0] = 12'h100;
        req_addr_in[1] = 12'h200;
        req_addr_in[2] = 12'h300;
        mem_ready_in   = 1'b1;
        mem_valid_in   = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            ch      = k % 3;
            exp_gnt = 3'b001 << ch;
            check($sformatf("rr_grant%0d", k), 32'(req_ready_out), 32'(exp_gnt));
            tick();
            #1;
            check($sformatf("rr_addr%0d", k), 32'(mem_addr_out), 32'h100 * (ch + 1));
            tick();
            mem_data_in = 16'(16'h1000 + k);
            #1;
            tick();
            if (k == 5) req_valid_in = '0;
            #1;
            check($sformatf("rr_resp%0d", k), 32'(resp_valid_out), 32'(exp_gnt));
            check($sformatf("rr_data%0d", k), 32'(resp_data_out), 32'h1000 + k);
            tick();
            #1;
        end
        mem_valid_in = 1'b0;
        mem_ready_in = 1'b0;

        // Downstream stalls ISSUE for 5 cycles.
        req_valid_in   = 3'b001;
        req_addr_in[0] = 12'h234;
        #1;
        check("st_ready", 32'(req_ready_out), 32'b001);
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) req_valid_in = '0;
            #1;
            check($sformatf("st_valid%0d", c), 32'(mem_valid_out), 1);
            check($sformatf("st_addr%0d", c),  32'(mem_addr_out),  32'h234);
        end
        tick();
        mem_ready_in = 1'b1;
        #1;
        check("st_valid6", 32'(mem_valid_out), 1);
        tick();
        mem_ready_in = 1'b0;
        mem_valid_in = 1'b1;
        mem_data_in  = 16'h1234;
        #1;
        check("st_wait_valid", 32'(mem_valid_out),  0);
        check("st_wait_resp",  32'(resp_valid_out), 0);
        tick();
        mem_valid_in = 1'b0;
        #1;
        check("st_resp_valid", 32'(resp_valid_out), 32'b001);
        check("st_resp_data",  32'(resp_data_out),  32'h1234);
        tick();
        #1;

        // Reset asserted while in WAIT drops the transaction.
        req_valid_in   = 3'b010;
        req_addr_in[1] = 12'h345;
        mem_ready_in   = 1'b1;
        #1;
        check("rw_ready", 32'(req_ready_out), 32'b010);
        tick();
        req_valid_in = '0;
        #1;
        check("rw_issue", 32'(mem_valid_out), 1);
        tick();
        mem_ready_in = 1'b0;
        #1;
        check("rw_wait_addr", 32'(mem_addr_out), 32'h345);
        req_valid_in = 3'b001;
        mem_valid_in = 1'b1;
        rst_in       = 1'b0;
        #1;
        check("rw_rst_ready", 32'(req_ready_out),  0);
        check("rw_rst_addr",  32'(mem_addr_out),   0);
        check("rw_rst_valid", 32'(mem_valid_out),  0);
        check("rw_rst_resp",  32'(resp_valid_out), 0);
        req_valid_in = '0;
        rst_in       = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            tick();
            #1;
            check($sformatf("rw_no_resp%0d", c), 32'(resp_valid_out), 0);
        end
        mem_valid_in = 1'b0;

        // Word write by ch2 after reset.
        req_valid_in   = 3'b100;
        req_addr_in[2] = 12'h300;
        req_data_in[2] = 16'hABCD;
        req_we_in[2]   = 1'b1;
        req_size_in[2] = 1'b1;
        req_type_in[2] = 2'd2;
        mem_ready_in   = 1'b1;
        #1;
        check("wr_ready", 32'(req_ready_out), 32'b100);
        tick();
        req_valid_in = '0;
        #1;
        check("wr_mem_valid", 32'(mem_valid_out), 1);
        check("wr_mem_addr",  32'(mem_addr_out),  32'h300);
        check("wr_mem_data",  32'(mem_data_out),  32'hABCD);
        check("wr_mem_we",    32'(mem_we_out),    1);
        check("wr_mem_size",  32'(mem_size_out),  1);
        check("wr_mem_type",  32'(mem_type_out),  2);
        tick();
        mem_ready_in = 1'b0;
        mem_valid_in = 1'b1;
        mem_data_in  = 16'h5555;
        #1;
        tick();
        mem_valid_in = 1'b0;
        #1;
        check("wr_resp_valid", 32'(resp_valid_out), 32'b100);
        check("wr_resp_data",  32'(resp_data_out),  0);
        tick();
        #1;
        check("wr_resp_pulse", 32'(resp_valid_out), 0);

`ifdef CHIP8_ARB_TIMEOUT_EN
        // Memory never accepts: watchdog completes with error.
        req_valid_in = 3'b001;
        #1;
        check("to_ready", 32'(req_ready_out), 32'b001);
        tick();
        req_valid_in = '0;
        repeat (15) tick();
        #1;
        check("to_early_resp",  32'(resp_valid_out), 0);
        check("to_still_valid", 32'(mem_valid_out),  1);
        tick();
        #1;
        check("to_resp_valid", 32'(resp_valid_out), 32'b001);
        check("to_resp_err",   32'(resp_err_out),   32'b001);
        check("to_resp_data",  32'(resp_data_out),  0);
        check("to_mem_valid",  32'(mem_valid_out),  0);
        tick();
        #1;
        check("to_err_clear", 32'(resp_err_out), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
